// File: rtl/enigma_input_arbiter.sv
// rtl/enigma_input_arbiter.sv - round-robin arbiter sharing one enigma encrypt core between two character sources
// Optional watchdog in WAIT enabled by defining ARB_TIMEOUT_EN.
module enigma_input_arbiter #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       a_valid,
    input  logic [7:0] a_char,
    output logic       a_ready,
    output logic       a_resp_valid,
    input  logic       b_valid,
    input  logic [7:0] b_char,
    output logic       b_ready,
    output logic       b_resp_valid,
    output logic [7:0] resp_char,
    output logic       mux_sel,
    output logic       core_start,
    output logic [7:0] core_char,
    input  logic       core_done,
    input  logic [7:0] core_result,
    output logic       busy,
    output logic       last_grant,
    output logic       timeout_err
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;

    if (TIMEOUT_CYCLES >= (1 << CNT_W)) begin : g_cnt_w_too_small
        $error("CNT_W too narrow for TIMEOUT_CYCLES");
    end

    logic [1:0] state;
    logic       grant;
    logic       winner;
    logic       take;
    logic       wd_hit;

    // Ties go to the side that did not complete last; last_grant resets to 1 so A wins first.
    always_comb begin
        winner = b_valid & (~a_valid | ~last_grant);
        take   = ~reset & (state == S_IDLE) & (a_valid | b_valid);
    end

    assign a_ready    = take & ~winner;
    assign b_ready    = take & winner;
    assign busy       = (state != S_IDLE);
    assign mux_sel    = busy & grant;
    assign core_start = (state == S_ISSUE);

`ifdef ARB_TIMEOUT_EN
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] wd_cnt;

    // A core_done arriving on the limit cycle still completes normally.
    assign wd_hit = (state == S_WAIT) & ~core_done & ((wd_cnt + CNT_ONE) == CNT_LIM);

    always_ff @(posedge clk) begin
        if (reset) begin
            wd_cnt      <= '0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= wd_hit;
            if (state != S_WAIT)
                wd_cnt <= '0;
            else if (!core_done)
                wd_cnt <= wd_cnt + CNT_ONE;
        end
    end
`else
    assign wd_hit      = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            grant        <= 1'b0;
            last_grant   <= 1'b1;
            core_char    <= 8'h00;
            resp_char    <= 8'h00;
            a_resp_valid <= 1'b0;
            b_resp_valid <= 1'b0;
        end else begin
            a_resp_valid <= 1'b0;
            b_resp_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (a_valid | b_valid) begin
                        grant     <= winner;
                        core_char <= winner ? b_char : a_char;
                        state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (core_done) begin
                        resp_char    <= core_result;
                        a_resp_valid <= ~grant;
                        b_resp_valid <= grant;
                        last_grant   <= grant;
                        state        <= S_IDLE;
                    end else if (wd_hit) begin
                        last_grant <= grant;
                        state      <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/enigma_input_arbiter.md
Name: enigma_input_arbiter

Overview:
- Shares the single enigma encrypt core between two character sources: A (keyboard) and B (replay/config stream).
- Accepts one character at a time from a requester and drives the 2:1 input mux select toward the core.
- Issues a start pulse and waits for the core's done.
- Returns the encrypted character to the requester that owns the grant.
- Round-robin fairness on ties; one transaction in flight at a time.

Parameters:
- TIMEOUT_CYCLES, 255: watchdog limit in WAIT, in clk cycles; only used with ARB_TIMEOUT_EN.
- CNT_W, 8: watchdog counter width; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- a_valid  in  1  requester A has a character
- a_char  in  8  requester A character
- a_ready  out  1  A's character accepted this cycle (valid&ready = transfer)
- a_resp_valid  out  1  one-cycle pulse: resp_char belongs to A
- b_valid  in  1  requester B has a character
- b_char  in  8  requester B character
- b_ready  out  1  B's character accepted this cycle
- b_resp_valid  out  1  one-cycle pulse: resp_char belongs to B
- resp_char  out  8  encrypted result, shared by both requesters
- mux_sel  out  1  datapath mux select; 0 = A, 1 = B
- core_start  out  1  one-cycle start pulse to the core
- core_char  out  8  latched character presented to the core
- core_done  in  1  core result valid (single-cycle pulse)
- core_result  in  8  core output character
- busy  out  1  high whenever the state is not IDLE
- last_grant  out  1  requester of the most recently completed transaction
- timeout_err  out  1  one-cycle watchdog pulse (tied 0 without the macro)

Behaviour:
- State machine: IDLE → ISSUE → WAIT → IDLE.
- Reset (synchronous, takes priority over every other event):
  - State goes to IDLE.
  - All outputs go to 0, except last_grant, which resets to 1 so A wins the first tie.
  - Reset during ISSUE or WAIT abandons the transaction: no resp pulse, and a later core_done is ignored.
- IDLE, grant selection:
  - Only a_valid set: winner A. Only b_valid set: winner B.
  - Both set: winner is !last_grant.
  - Neither set: stay in IDLE.
- IDLE, accept handshake:
  - x_ready is combinational and asserted only for the winner, only in IDLE.
  - On that edge, the winner's char is latched into core_char and the grant register is set.
  - State moves to ISSUE.
  - The loser's ready stays 0; its valid/char must be held until accepted.
- ISSUE: core_start = 1 for exactly one cycle, then WAIT.
- mux_sel:
  - Equals the grant register during ISSUE and WAIT.
  - Is 0 in IDLE.
  - Never changes while busy.
- WAIT:
  - On core_done: resp_char <= core_result; x_resp_valid for the granted side pulses high on the next cycle; last_grant <= grant; state returns to IDLE.
  - core_done outside WAIT is ignored.
- Latency: accept at edge N, core_start high in cycle N+1, earliest core_done in N+2, resp pulse in N+3. Back-to-back acceptance is possible in cycle N+3 (IDLE).
- resp_char holds its value until the next completion.
- core_char holds its value until the next acceptance.
- busy = (state != IDLE).
- a_ready and b_ready are never high in the same cycle.
- a_resp_valid and b_resp_valid are never high in the same cycle.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - CNT_W-bit counter clears on entering WAIT and increments each WAIT cycle without core_done.
  - When the count reaches TIMEOUT_CYCLES: timeout_err pulses one cycle, no resp pulse, last_grant <= grant, state returns to IDLE.
  - core_done in the same cycle as the timeout wins: normal completion, no error.
- Undefined: no counter logic; timeout_err tied 0; WAIT is held indefinitely until core_done.

Test Plan:
- Reset, then a_valid=1, a_char=8'h41; core_done two cycles after core_start with core_result=8'h5A → expect:
  - a_ready high for 1 cycle, mux_sel=0 during busy.
  - core_char=8'h41, single core_start pulse.
  - a_resp_valid pulse with resp_char=8'h5A; last_grant=0.
- Both valid from reset (a_char=8'h41, b_char=8'h42), held high across transactions → grant order A, B, A, B; mux_sel toggles 0,1,0,1; b_ready never high while busy.
- b_valid only, b_char=8'h7A; core_result=8'h10 → b_resp_valid pulse, resp_char=8'h10, a_resp_valid stays 0, mux_sel=1 throughout busy.
- Spurious core_done in IDLE with core_result=8'hFF → no resp pulse, resp_char unchanged, state remains IDLE.
- Reset asserted in WAIT, then core_done next cycle → all outputs 0, no resp pulse; next a_valid is accepted normally.
- ARB_TIMEOUT_EN with TIMEOUT_CYCLES=4, core_done never asserted → timeout_err pulse after 4 WAIT cycles, busy drops, next request is accepted; without the macro, busy stays high.
